// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry and the complex sample layout.
// Also used by butterfly_stage.
package fft_pkg;
  localparam int DATA_W   = 50;
  localparam int N_POINTS = 8;
  localparam int IDX_W    = $clog2(N_POINTS);

  typedef struct packed {
    logic signed [24:0] re;
    logic signed [24:0] im;
  } cplx_t;
endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: bin storage, a written-index mask and the frame-full flag.
// The parent only enables writes while this bank is not full.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int NP = N_POINTS,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_clr,
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          wr_dup,
  output logic          wr_done
);

  logic [DW-1:0] mem [NP];
  logic [NP-1:0] mask;
  logic [NP-1:0] mask_nxt;
  logic [NP-1:0] sel;

  always_comb begin
    sel         = '0;
    sel[wr_idx] = 1'b1;
    mask_nxt    = mask | sel;
    wr_dup      = wr_en & mask[wr_idx];
    // The completing write counts toward the mask before the full check.
    wr_done     = wr_en & (&mask_nxt);
  end

  // Storage carries no reset; the mask alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      full <= 1'b0;
    end else begin
      if (wr_done) begin
        mask <= '0;
        full <= 1'b1;
      end else if (wr_en) begin
        mask <= mask_nxt;
      end
      if (rd_clr) full <= 1'b0;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fft_output_reorder.sv
// Collects out-of-order FFT bins into ping-pong banks and streams each frame
// out in natural bin order with a valid/ready handshake.
module fft_output_reorder #(
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int N_POINTS = fft_pkg::N_POINTS,
  localparam int IDX_W   = $clog2(N_POINTS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [IDX_W-1:0]  in_idx_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_last_o,
  output logic              dup_err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  logic                   wr_bank;
  logic                   rd_bank;
  logic [IDX_W-1:0]       rd_cnt;
  logic                   dup_err;
  logic [1:0]             full;
  logic [1:0]             wr_en;
  logic [1:0]             rd_clr;
  logic [1:0]             wr_dup;
  logic [1:0]             wr_done;
  logic [1:0][DATA_W-1:0] rd_data;
  logic                   wr_fire;
  logic                   rd_fire;
  logic                   rd_wrap;

  assign in_ready_o = !full[wr_bank];
  assign wr_fire    = in_valid_i & in_ready_o;
  assign rd_fire    = out_valid_o & out_ready_i;
  assign rd_wrap    = rd_fire & (rd_cnt == LAST_IDX);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_en[b]  = wr_fire & (wr_bank == 1'(b));
    assign rd_clr[b] = rd_wrap & (rd_bank == 1'(b));

    fft_reorder_bank #(
      .DW (DATA_W),
      .NP (N_POINTS),
      .IW (IDX_W)
    ) u_bank (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .wr_en   (wr_en[b]),
      .wr_idx  (in_idx_i),
      .wr_data (in_data_i),
      .rd_clr  (rd_clr[b]),
      .rd_idx  (rd_cnt),
      .rd_data (rd_data[b]),
      .full    (full[b]),
      .wr_dup  (wr_dup[b]),
      .wr_done (wr_done[b])
    );
  end

  // Write and read sides advance independently, so a frame can complete on
  // one bank while the other bank's final read retires on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      dup_err <= 1'b0;
    end else begin
      if (|wr_done) wr_bank <= ~wr_bank;
      if (|wr_dup)  dup_err <= 1'b1;
      if (rd_fire) begin
        rd_cnt <= rd_wrap ? '0 : rd_cnt + 1'b1;
        if (rd_wrap) rd_bank <= ~rd_bank;
      end
    end
  end

  assign out_valid_o = full[rd_bank];
  assign out_idx_o   = rd_cnt;
  assign out_data_o  = out_valid_o ? rd_data[rd_bank] : '0;
  assign out_last_o  = out_valid_o & (rd_cnt == LAST_IDX);
  assign dup_err_o   = dup_err;

endmodule

// File: doc/fft_output_reorder.md
FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 50, meaning complex sample width: [49:25] signed real, [24:0] signed imag.
REQ-002 The block SHALL have parameter N_POINTS, default 8, meaning FFT frame length, which is the number of bins per bank.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid_i, input, 1 bit: the butterfly-stage result on in_data_i/in_idx_i is valid.
REQ-006 The block SHALL have port in_data_i, input, DATA_W bits: final-stage bin value.
REQ-007 The block SHALL have port in_idx_i, input, 3 bits: bin index of in_data_i, arriving in any order.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit: the write bank can accept a sample.
REQ-009 The block SHALL have port out_valid_o, output, 1 bit: out_data_o/out_idx_o are valid.
REQ-010 The block SHALL have port out_ready_i, input, 1 bit: the downstream consumer accepts the current output.
REQ-011 The block SHALL have port out_data_o, output, DATA_W bits: bin value in natural order.
REQ-012 The block SHALL have port out_idx_o, output, 3 bits: bin index of out_data_o.
REQ-013 The block SHALL have port out_last_o, output, 1 bit: asserted with bin N_POINTS-1.
REQ-014 The block SHALL have port dup_err_o, output, 1 bit: sticky flag, set when an index is written twice within one frame.

Function
REQ-015 The block SHALL contain two banks (ping-pong) of N_POINTS x DATA_W storage, each with an N_POINTS-bit written mask and a full flag.
REQ-016 A write SHALL occur when in_valid_i & in_ready_o: store in_data_i at wr_bank[in_idx_i] and set mask[in_idx_i].
REQ-017 in_ready_o SHALL equal !full[wr_bank].
REQ-018 When a write completes the mask (all ones including the current write), the block SHALL set full[wr_bank], clear that mask and toggle wr_bank on the same edge.
REQ-019 A write to an index whose mask bit is already set SHALL overwrite the data, leave the mask unchanged and set dup_err_o, which is cleared only by reset.
REQ-020 out_valid_o SHALL equal full[rd_bank]; out_idx_o SHALL equal rd_cnt; out_data_o SHALL equal rd_bank[rd_cnt] while out_valid_o=1, and 0 otherwise.
REQ-021 On out_valid_o & out_ready_i, rd_cnt SHALL increment; at rd_cnt=N_POINTS-1 it SHALL wrap to 0, clear full[rd_bank] and toggle rd_bank.
REQ-022 out_last_o SHALL equal out_valid_o & (rd_cnt==N_POINTS-1).
REQ-023 Latency: out_valid_o SHALL rise on the first edge after the write that completes a frame.
REQ-024 Output data and index SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-025 If both banks are full, in_ready_o SHALL be 0 and in_valid_i SHALL be ignored, with no data or mask change.
REQ-026 When the last write to one bank and the last read of the other bank occur on the same edge, both SHALL take effect: the first bank becomes full and the second becomes free.
REQ-027 Writes to a free bank SHALL never corrupt the bank being read.

Reset
REQ-028 On rst_i=0 the block SHALL asynchronously clear both masks, both full flags, wr_bank, rd_bank, rd_cnt and dup_err_o.
REQ-029 During reset, in_ready_o SHALL be 1 and out_valid_o, out_last_o, out_idx_o, out_data_o and dup_err_o SHALL be 0.
REQ-030 Storage arrays SHALL NOT be reset.
REQ-031 Reset asserted mid-frame or mid-readout SHALL discard all partial and pending frames.
REQ-032 After reset deassertion, the first accepted sample SHALL go to bank 0.

Structure
REQ-033 Package fft_pkg SHALL hold DATA_W, N_POINTS, IDX_W=$clog2(N_POINTS) and typedef cplx_t (signed re, signed im, 25 bits each); this package is shared with butterfly_stage.
REQ-034 One sub-module, fft_reorder_bank (storage, mask and full flag for one bank), SHALL be instantiated twice.
REQ-035 Bank selection, rd_cnt and the handshakes SHALL reside in fft_output_reorder.

Verification
REQ-036 Scenario: write idx 7,6,...,0 with data=idx*3, out_ready_i=1 -> out_valid_o rises 1 cycle after the idx-0 write; outputs idx 0..7 with data 0,3,...,21 on consecutive cycles; out_last_o only with idx 7.
REQ-037 Scenario: three frames back-to-back with out_ready_i=0 -> frames 1 and 2 accepted; in_ready_o=0 after the 16th write; frame 3 stalls until out_ready_i=1 and the first bank drains.
REQ-038 Scenario: idx 2 written twice (0x5 then 0xA), then the remaining indices -> dup_err_o=1 from the second write; bin 2 reads 0xA; frame completes after 8 distinct indices.
REQ-039 Scenario: the bank-0 read finishes on the same edge as the bank-1 8th write -> bank 1 is output next cycle with no bubble; in_ready_o=1.
REQ-040 Scenario: assert rst_i=0 after 4 outputs of a frame -> all outputs 0 and in_ready_o=1 immediately; a fresh frame afterwards reads correctly from bank 0.
REQ-041 Scenario: random out_ready_i (50%) over 100 random-order frames -> the scoreboard sees every frame in natural order with no loss or duplication.
